// File: rtl/rng_request_arbiter_if.sv
// Request, RNG and delivery bundle shared by the
// RNG request arbiter and its requesters.
interface rng_request_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int VAL_W   = 3
);
    logic [NUM_REQ-1:0] req;
    logic               gen_o;
    logic [VAL_W-1:0]   rng_num_i;
    logic [NUM_REQ-1:0] grant_o;
    logic [VAL_W-1:0]   data_o;
    logic [NUM_REQ-1:0] valid_o;
    logic               busy_o;

    modport master (
        output req, rng_num_i,
        input  gen_o, grant_o, data_o, valid_o, busy_o
    );
    modport slave (
        input  req, rng_num_i,
        output gen_o, grant_o, data_o, valid_o, busy_o
    );
endinterface

// File: rtl/rng_request_arbiter.sv
// Round-robin arbiter sharing one RNG among requesters,
// with optional per-requester no-repeat redraw.
module rng_request_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int VAL_W     = 3,
    parameter int NO_REPEAT = 1,
    parameter int MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                reset,
    rng_request_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        WAIT,
        DELIVER
    } state_t;

    state_t                          state_q, state_d;
    logic [IW-1:0]                   last_q, last_d;
    logic [IW-1:0]                   gidx_q, gidx_d;
    logic [RW-1:0]                   retry_q, retry_d;
    logic                            gen_q, gen_d;
    logic [NUM_REQ-1:0]              grant_q, grant_d;
    logic [VAL_W-1:0]                data_q, data_d;
    logic [NUM_REQ-1:0]              valid_q, valid_d;
    logic                            busy_q, busy_d;
    logic [NUM_REQ-1:0][VAL_W-1:0]   lval_q, lval_d;
    logic [NUM_REQ-1:0]              lflag_q, lflag_d;

    logic          found;
    logic [IW-1:0] sel;
    logic [IW-1:0] cand;
    logic          reject;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        retry_d = retry_q;
        gen_d   = 1'b0;
        grant_d = grant_q;
        data_d  = data_q;
        valid_d = '0;
        lval_d  = lval_q;
        lflag_d = lflag_q;
        found   = 1'b0;
        sel     = '0;
        cand    = '0;

        // Search starts just past the last served requester.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last_q) + i) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        reject = (NO_REPEAT != 0) && lflag_q[gidx_q] &&
                 (bus.rng_num_i == lval_q[gidx_q]) &&
                 (retry_q < RMAX);

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gidx_d  = sel;
                    grant_d = NUM_REQ'(1) << sel;
                    retry_d = '0;
                    gen_d   = 1'b1;
                    state_d = GEN;
                end
            end
            GEN: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (reject) begin
                    retry_d = retry_q + 1'b1;
                    gen_d   = 1'b1;
                    state_d = GEN;
                end else begin
                    data_d  = bus.rng_num_i;
                    valid_d = grant_q;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                lval_d[gidx_q]  = data_q;
                lflag_d[gidx_q] = 1'b1;
                last_d          = gidx_q;
                grant_d         = '0;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= LAST_INIT;
            gidx_q  <= '0;
            retry_q <= '0;
            gen_q   <= 1'b0;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= '0;
            busy_q  <= 1'b0;
            lval_q  <= '0;
            lflag_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            retry_q <= retry_d;
            gen_q   <= gen_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            lval_q  <= lval_d;
            lflag_q <= lflag_d;
        end
    end

    assign bus.gen_o   = gen_q;
    assign bus.grant_o = grant_q;
    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = busy_q;
endmodule

// File: tb/tb_rng_request_arbiter.sv
// Scoreboard bench for rng_request_arbiter: a transaction-level
// model predicts winner, value and delivery edge per service.
module tb_rng_request_arbiter;
    localparam int N     = 4;
    localparam int VW    = 3;
    localparam int NOREP = 1;
    localparam int MAXR  = 3;
    localparam int TABSZ = 4096;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req_r = '0;
    logic [VW-1:0] rng_q = '0;

    always #5 clk = ~clk;

    rng_request_arbiter_if #(.NUM_REQ(N), .VAL_W(VW)) bus ();

    assign bus.req       = req_r;
    assign bus.rng_num_i = rng_q;

    rng_request_arbiter #(
        .NUM_REQ  (N),
        .VAL_W    (VW),
        .NO_REPEAT(NOREP),
        .MAX_RETRY(MAXR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // Bench RNG: next table entry on every sampled generate strobe
    logic [VW-1:0] tab [TABSZ];
    int rdraw = 0;

    always @(posedge clk) begin
        if (bus.gen_o) begin
            rng_q <= tab[rdraw % TABSZ];
            rdraw <= rdraw + 1;
        end
    end

    typedef struct {
        int            e;
        int            idx;
        logic [VW-1:0] val;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mx;
    int            edge_n    = 0;
    int            idle_edge = 0;
    int            m_last    = N - 1;
    int            mdraw     = 0;
    int            exp_gens  = 0;
    int            seen_gens = 0;
    bit            m_have [N];
    logic [VW-1:0] m_val  [N];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)",
                     name, act, exp, edge_n);
        end
    endtask

    // One whole service, computed from the arbitration and redraw rules
    task automatic serve();
        int w;
        int r;
        logic [VW-1:0] v;
        w = -1;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (m_last + i) % N;
            if (w < 0 && req_r[k]) w = k;
        end
        r = 0;
        v = tab[mdraw % TABSZ];
        mdraw++;
        while (NOREP != 0 && m_have[w] && v == m_val[w] && r < MAXR) begin
            r++;
            v = tab[mdraw % TABSZ];
            mdraw++;
        end
        sbq.push_back('{e: edge_n + 2 + 2 * r, idx: w, val: v});
        m_have[w] = 1'b1;
        m_val[w]  = v;
        m_last    = w;
        exp_gens += r + 1;
        idle_edge = edge_n + 4 + 2 * r;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (reset) begin
                idle_edge = edge_n + 1;
                m_last    = N - 1;
                for (int i = 0; i < N; i++) m_have[i] = 1'b0;
                mdraw    = rdraw;
                exp_gens = seen_gens;
                sbq.delete();
            end else if (edge_n == idle_edge) begin
                if (req_r == '0) idle_edge++;
                else serve();
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bus.gen_o) seen_gens++;
            if (bus.valid_o != '0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: valid_o=%b data_o=%0d edge=%0d, required no delivery",
                             bus.valid_o, bus.data_o, edge_n);
                end else begin
                    mx = sbq.pop_front();
                    chk("deliver_edge", edge_n, mx.e);
                    chk("valid_onehot", int'(bus.valid_o), 1 << mx.idx);
                    chk("data_o", int'(bus.data_o), int'(mx.val));
                    chk("grant_at_valid", int'(bus.grant_o), 1 << mx.idx);
                end
            end
        end
    end

    task automatic chk_zero_outputs(string tag);
        chk({tag, "_gen"}, int'(bus.gen_o), 0);
        chk({tag, "_grant"}, int'(bus.grant_o), 0);
        chk({tag, "_data"}, int'(bus.data_o), 0);
        chk({tag, "_valid"}, int'(bus.valid_o), 0);
        chk({tag, "_busy"}, int'(bus.busy_o), 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || edge_n + 1 < idle_edge) && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_timeout", int'(n >= 300), 0);
        chk("idle_busy", int'(bus.busy_o), 0);
        chk("gen_count", seen_gens, exp_gens);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < TABSZ; i++) begin
            tab[i] = (i % 3 == 0) ? VW'($urandom_range(0, 7))
                                  : VW'($urandom_range(0, 1));
        end
        #1 reset = 1'b1;
        #1 chk_zero_outputs("reset");
        repeat (2) @(negedge clk);

        // Single request, value 2: gen on cycle 1, idle again on cycle 4
        tab[rdraw % TABSZ] = 3'd2;
        reset = 1'b0;
        req_r = 4'b0001;
        @(posedge clk);
        #1 chk("t1_gen_cycle1", int'(bus.gen_o), 1);
        req_r = '0;
        repeat (3) @(posedge clk);
        #1 chk("t1_busy_cycle4", int'(bus.busy_o), 0);
        wait_idle();

        // All four requesting: strict rotation 0,1,2,3
        do_reset();
        tab[(rdraw + 0) % TABSZ] = 3'd1;
        tab[(rdraw + 1) % TABSZ] = 3'd3;
        tab[(rdraw + 2) % TABSZ] = 3'd0;
        tab[(rdraw + 3) % TABSZ] = 3'd4;
        req_r = 4'b1111;
        repeat (13) @(negedge clk);
        req_r = '0;
        wait_idle();

        // Repeat of 3 redrawn once, then 1 delivered
        do_reset();
        tab[(rdraw + 0) % TABSZ] = 3'd3;
        tab[(rdraw + 1) % TABSZ] = 3'd3;
        tab[(rdraw + 2) % TABSZ] = 3'd1;
        req_r = 4'b0001;
        repeat (5) @(negedge clk);
        req_r = '0;
        wait_idle();

        // Stuck RNG: second service exhausts its redraws
        do_reset();
        for (int i = 0; i < 8; i++) tab[(rdraw + i) % TABSZ] = 3'd4;
        req_r = 4'b0001;
        repeat (5) @(negedge clk);
        req_r = '0;
        wait_idle();

        // Request dropped in GEN still delivers; requester 1 next
        do_reset();
        req_r = 4'b0100;
        @(negedge clk);
        req_r = 4'b0010;
        repeat (5) @(negedge clk);
        req_r = '0;
        wait_idle();

        // Reset in WAIT aborts the service and forgets last values
        do_reset();
        tab[(rdraw + 0) % TABSZ] = 3'd5;
        tab[(rdraw + 1) % TABSZ] = 3'd5;
        req_r = 4'b0001;
        repeat (5) @(negedge clk);
        req_r = '0;
        @(negedge clk);
        reset = 1'b1;
        #1 chk_zero_outputs("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tab[rdraw % TABSZ] = 3'd5;
        repeat (3) @(negedge clk);
        req_r = 4'b0001;
        @(negedge clk);
        req_r = '0;
        wait_idle();

        // Random request traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req_r = N'($urandom_range(0, 15));
        end
        req_r = '0;
        wait_idle();
        chk("sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
